// File: rtl/doa_sequencer.sv
// Frame sequencer for the direction-of-arrival path: owns the four FFT RAM read
// ports, runs peak detection then beam weighting per frame, and reports the result.
module doa_sequencer #(
    parameter int unsigned TIMEOUT = 4095,
    parameter int unsigned MINBIN  = 1,
    parameter int unsigned MAXBIN  = 511
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fftdone,
    input  logic [9:0] det_rdaddr,
    input  logic       detectdone,
    input  logic [9:0] maxbin,
    input  logic       peakvalid,
    input  logic [9:0] wb_rdaddr2,
    input  logic [9:0] wb_rdaddr3,
    input  logic [9:0] wb_rdaddr4,
    input  logic       wbdone,
    input  logic [5:0] bnum,
    input  logic [7:0] doa,
    output logic [9:0] rdaddr1,
    output logic [9:0] rdaddr2,
    output logic [9:0] rdaddr3,
    output logic [9:0] rdaddr4,
    output logic       detectstart,
    output logic       wbstart,
    output logic [9:0] wb_maxbin,
    output logic       fft_hold,
    output logic       result_valid,
    output logic [7:0] doa_out,
    output logic [5:0] bnum_out,
    output logic [7:0] frames_dropped,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DETECT = 2'd1,
        WEIGHT = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam logic [11:0] TIMEOUT_L = 12'(TIMEOUT);
    localparam logic [9:0]  MINBIN_L  = 10'(MINBIN);
    localparam logic [9:0]  MAXBIN_L  = 10'(MAXBIN);

    state_t      state_r, state_nxt_s;
    logic [11:0] wdog_r;
    logic        wdog_expired_s;
    logic        enter_detect_s, enter_weight_s, wb_take_s, tmo_s, drop_s;
    logic        detectstart_r, wbstart_r, fft_hold_r, result_valid_r, timeout_err_r;
    logic [9:0]  wb_maxbin_r;
    logic [7:0]  doa_out_r, frames_dropped_r;
    logic [5:0]  bnum_out_r;

    function automatic logic bin_in_range(input logic [9:0] bin);
        return (bin >= MINBIN_L) && (bin <= MAXBIN_L);
    endfunction

    assign wdog_expired_s = (wdog_r == TIMEOUT_L);

    // Next-state logic and per-cycle event strobes; done pulses take priority over the watchdog.
    always_comb begin
        state_nxt_s    = state_r;
        enter_detect_s = 1'b0;
        enter_weight_s = 1'b0;
        wb_take_s      = 1'b0;
        tmo_s          = 1'b0;
        drop_s         = 1'b0;
        case (state_r)
            IDLE: begin
                if (fftdone) begin
                    state_nxt_s    = DETECT;
                    enter_detect_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DETECT: begin
                drop_s = fftdone;
                if (detectdone) begin
                    if (peakvalid && bin_in_range(maxbin)) begin
                        state_nxt_s    = WEIGHT;
                        enter_weight_s = 1'b1;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else if (wdog_expired_s) begin
                    state_nxt_s = IDLE;
                    tmo_s       = 1'b1;
                end else begin
                    state_nxt_s = DETECT;
                end
            end
            WEIGHT: begin
                drop_s = fftdone;
                if (wbdone) begin
                    state_nxt_s = REPORT;
                    wb_take_s   = 1'b1;
                end else if (wdog_expired_s) begin
                    state_nxt_s = IDLE;
                    tmo_s       = 1'b1;
                end else begin
                    state_nxt_s = WEIGHT;
                end
            end
            REPORT: begin
                if (fftdone) begin
                    state_nxt_s    = DETECT;
                    enter_detect_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Read-port mux: combinational so detector/weightblock addresses see no extra latency.
    always_comb begin
        rdaddr1 = wb_maxbin_r;
        rdaddr2 = wb_maxbin_r;
        rdaddr3 = wb_maxbin_r;
        rdaddr4 = wb_maxbin_r;
        case (state_r)
            DETECT: begin
                rdaddr1 = det_rdaddr;
                rdaddr2 = 10'd0;
                rdaddr3 = 10'd0;
                rdaddr4 = 10'd0;
            end
            WEIGHT: begin
                rdaddr1 = wb_maxbin_r;
                rdaddr2 = wb_rdaddr2;
                rdaddr3 = wb_rdaddr3;
                rdaddr4 = wb_rdaddr4;
            end
            default: begin
                rdaddr1 = wb_maxbin_r;
                rdaddr2 = wb_maxbin_r;
                rdaddr3 = wb_maxbin_r;
                rdaddr4 = wb_maxbin_r;
            end
        endcase
    end

    // State, watchdog, latched results and status registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r          <= IDLE;
            wdog_r           <= 12'd0;
            detectstart_r    <= 1'b0;
            wbstart_r        <= 1'b0;
            fft_hold_r       <= 1'b0;
            result_valid_r   <= 1'b0;
            timeout_err_r    <= 1'b0;
            wb_maxbin_r      <= 10'd0;
            doa_out_r        <= 8'd0;
            bnum_out_r       <= 6'd0;
            frames_dropped_r <= 8'd0;
        end else begin
            state_r        <= state_nxt_s;
            detectstart_r  <= enter_detect_s;
            wbstart_r      <= enter_weight_s;
            result_valid_r <= wb_take_s;
            fft_hold_r     <= (state_nxt_s != IDLE);
            timeout_err_r  <= timeout_err_r | tmo_s;
            if (enter_detect_s || enter_weight_s) begin
                wdog_r <= 12'd0;
            end else if ((state_r == DETECT) || (state_r == WEIGHT)) begin
                wdog_r <= wdog_r + 12'd1;
            end else begin
                wdog_r <= wdog_r;
            end
            if (enter_weight_s) begin
                wb_maxbin_r <= maxbin;
            end else begin
                wb_maxbin_r <= wb_maxbin_r;
            end
            if (wb_take_s) begin
                doa_out_r  <= doa;
                bnum_out_r <= bnum;
            end else begin
                doa_out_r  <= doa_out_r;
                bnum_out_r <= bnum_out_r;
            end
            if (drop_s && (frames_dropped_r != 8'hFF)) begin
                frames_dropped_r <= frames_dropped_r + 8'd1;
            end else begin
                frames_dropped_r <= frames_dropped_r;
            end
        end
    end

    assign detectstart    = detectstart_r;
    assign wbstart        = wbstart_r;
    assign fft_hold       = fft_hold_r;
    assign result_valid   = result_valid_r;
    assign timeout_err    = timeout_err_r;
    assign wb_maxbin      = wb_maxbin_r;
    assign doa_out        = doa_out_r;
    assign bnum_out       = bnum_out_r;
    assign frames_dropped = frames_dropped_r;

endmodule

// File: tb/tb_doa_sequencer.sv
// Self-checking bench for doa_sequencer: scenario tasks plus a result scoreboard
// that pairs every result_valid pulse with a queued expected angle/beam.
module tb_doa_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       fftdone, detectdone, peakvalid, wbdone;
    logic [9:0] det_rdaddr, maxbin, wb_rdaddr2, wb_rdaddr3, wb_rdaddr4;
    logic [5:0] bnum;
    logic [7:0] doa;
    logic [9:0] rdaddr1, rdaddr2, rdaddr3, rdaddr4, wb_maxbin;
    logic       detectstart, wbstart, fft_hold, result_valid, timeout_err;
    logic [7:0] doa_out, frames_dropped;
    logic [5:0] bnum_out;

    int          n_vec = 0;
    int          n_err = 0;
    logic [13:0] exp_q[$];
    logic [13:0] exp_e;

    doa_sequencer #(.TIMEOUT(100), .MINBIN(1), .MAXBIN(511)) dut (
        .clk(clk), .reset(reset), .fftdone(fftdone), .det_rdaddr(det_rdaddr),
        .detectdone(detectdone), .maxbin(maxbin), .peakvalid(peakvalid),
        .wb_rdaddr2(wb_rdaddr2), .wb_rdaddr3(wb_rdaddr3), .wb_rdaddr4(wb_rdaddr4),
        .wbdone(wbdone), .bnum(bnum), .doa(doa),
        .rdaddr1(rdaddr1), .rdaddr2(rdaddr2), .rdaddr3(rdaddr3), .rdaddr4(rdaddr4),
        .detectstart(detectstart), .wbstart(wbstart), .wb_maxbin(wb_maxbin),
        .fft_hold(fft_hold), .result_valid(result_valid), .doa_out(doa_out),
        .bnum_out(bnum_out), .frames_dropped(frames_dropped), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Scoreboard: every result_valid must match the oldest queued {doa, bnum}.
    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_result: got doa=%0d bnum=%0d, none expected", doa_out, bnum_out);
            end else begin
                exp_e = exp_q.pop_front();
                if ({doa_out, bnum_out} !== exp_e) begin
                    n_err++;
                    $display("FAIL result: got doa=%0d bnum=%0d, expected doa=%0d bnum=%0d",
                             doa_out, bnum_out, exp_e[13:6], exp_e[5:0]);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a frame from IDLE into WEIGHT with an accepted peak at bin.
    task automatic start_frame(input logic [9:0] bin);
        fftdone = 1'b1;
        tick();
        fftdone    = 1'b0;
        maxbin     = bin;
        peakvalid  = 1'b1;
        detectdone = 1'b1;
        tick();
        detectdone = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        fftdone = 1'b0; detectdone = 1'b0; peakvalid = 1'b0; wbdone = 1'b0;
        det_rdaddr = 10'd0; maxbin = 10'd0; wb_rdaddr2 = 10'd0; wb_rdaddr3 = 10'd0;
        wb_rdaddr4 = 10'd0; bnum = 6'd0; doa = 8'd0;
        tick();
        tick();
        n_vec++;
        if ({rdaddr1, rdaddr2, rdaddr3, rdaddr4, wb_maxbin, doa_out, bnum_out, frames_dropped,
             detectstart, wbstart, fft_hold, result_valid, timeout_err} !== 77'd0) begin
            n_err++;
            $display("FAIL reset_outputs: some output nonzero (fft_hold=%b wb_maxbin=%0d), expected all 0",
                     fft_hold, wb_maxbin);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_nominal();
        fftdone = 1'b1;
        tick();
        fftdone = 1'b0;
        n_vec++;
        if ({detectstart, fft_hold} !== 2'b11) begin
            n_err++;
            $display("FAIL nominal_detectstart: got start=%b hold=%b, expected 1 1", detectstart, fft_hold);
        end
        for (int i = 7; i <= 9; i++) begin
            det_rdaddr = 10'(i);
            #1;
            n_vec++;
            if ({rdaddr1, rdaddr2, rdaddr3, rdaddr4} !== {10'(i), 30'd0}) begin
                n_err++;
                $display("FAIL arb_detect: got %0d/%0d/%0d/%0d, expected %0d/0/0/0",
                         rdaddr1, rdaddr2, rdaddr3, rdaddr4, i);
            end
            tick();
        end
        n_vec++;
        if (detectstart !== 1'b0) begin
            n_err++;
            $display("FAIL detectstart_pulse: got %b, expected 0", detectstart);
        end
        maxbin = 10'd44; peakvalid = 1'b1; detectdone = 1'b1;
        tick();
        detectdone = 1'b0;
        n_vec++;
        if ({wbstart, wb_maxbin} !== {1'b1, 10'd44}) begin
            n_err++;
            $display("FAIL nominal_wbstart: got wbstart=%b wb_maxbin=%0d, expected 1 44", wbstart, wb_maxbin);
        end
        wb_rdaddr2 = 10'd100; wb_rdaddr3 = 10'd200; wb_rdaddr4 = 10'd300;
        #1;
        n_vec++;
        if ({rdaddr1, rdaddr2, rdaddr3, rdaddr4} !== {10'd44, 10'd100, 10'd200, 10'd300}) begin
            n_err++;
            $display("FAIL arb_weight: got %0d/%0d/%0d/%0d, expected 44/100/200/300",
                     rdaddr1, rdaddr2, rdaddr3, rdaddr4);
        end
        tick();
        n_vec++;
        if (wbstart !== 1'b0) begin
            n_err++;
            $display("FAIL wbstart_pulse: got %b, expected 0", wbstart);
        end
        bnum = 6'd5; doa = 8'd85; wbdone = 1'b1;
        exp_q.push_back({8'd85, 6'd5});
        tick();
        wbdone = 1'b0;
        n_vec++;
        if ({result_valid, fft_hold, doa_out, bnum_out} !== {1'b1, 1'b1, 8'd85, 6'd5}) begin
            n_err++;
            $display("FAIL nominal_result: got rv=%b hold=%b doa=%0d bnum=%0d, expected 1 1 85 5",
                     result_valid, fft_hold, doa_out, bnum_out);
        end
        tick();
        n_vec++;
        if ({result_valid, fft_hold, rdaddr3} !== {1'b0, 1'b0, 10'd44}) begin
            n_err++;
            $display("FAIL nominal_idle: got rv=%b hold=%b rdaddr3=%0d, expected 0 0 44",
                     result_valid, fft_hold, rdaddr3);
        end
    endtask

    task automatic test_reject();
        logic [10:0] cases [3];
        cases[0] = {1'b0, 10'd60};
        cases[1] = {1'b1, 10'd0};
        cases[2] = {1'b1, 10'd512};
        for (int i = 0; i < 3; i++) begin
            fftdone = 1'b1;
            tick();
            fftdone = 1'b0;
            {peakvalid, maxbin} = cases[i];
            detectdone = 1'b1;
            tick();
            detectdone = 1'b0;
            n_vec++;
            if ({wbstart, fft_hold, wb_maxbin, doa_out} !== {1'b0, 1'b0, 10'd44, 8'd85}) begin
                n_err++;
                $display("FAIL reject_%0d: got wbstart=%b hold=%b wb_maxbin=%0d doa=%0d, expected 0 0 44 85",
                         i, wbstart, fft_hold, wb_maxbin, doa_out);
            end
        end
    endtask

    task automatic test_stray();
        detectdone = 1'b1; peakvalid = 1'b1; maxbin = 10'd70;
        tick();
        detectdone = 1'b0; wbdone = 1'b1;
        tick();
        wbdone = 1'b0;
        tick();
        n_vec++;
        if ({wbstart, fft_hold, wb_maxbin} !== {1'b0, 1'b0, 10'd44}) begin
            n_err++;
            $display("FAIL stray_pulses: got wbstart=%b hold=%b wb_maxbin=%0d, expected 0 0 44",
                     wbstart, fft_hold, wb_maxbin);
        end
    endtask

    task automatic test_watchdog();
        int k;
        start_frame(10'd33);
        n_vec++;
        if ({wbstart, timeout_err} !== 2'b10) begin
            n_err++;
            $display("FAIL wdog_start: got wbstart=%b terr=%b, expected 1 0", wbstart, timeout_err);
        end
        k = 0;
        while (timeout_err !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        n_vec++;
        if (k < 100 || k > 102 || fft_hold !== 1'b0) begin
            n_err++;
            $display("FAIL wdog_expire: got %0d cycles hold=%b, expected 100..102 cycles hold=0", k, fft_hold);
        end
        start_frame(10'd50);
        bnum = 6'd3; doa = 8'd200; wbdone = 1'b1;
        exp_q.push_back({8'd200, 6'd3});
        tick();
        wbdone = 1'b0;
        n_vec++;
        if ({result_valid, doa_out, bnum_out, timeout_err} !== {1'b1, 8'd200, 6'd3, 1'b1}) begin
            n_err++;
            $display("FAIL wdog_recover: got rv=%b doa=%0d bnum=%0d terr=%b, expected 1 200 3 1",
                     result_valid, doa_out, bnum_out, timeout_err);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        start_frame(10'd44);
        for (int i = 0; i < 3; i++) begin
            fftdone = 1'b1;
            tick();
            fftdone = 1'b0;
            tick();
        end
        n_vec++;
        if (frames_dropped !== 8'd3) begin
            n_err++;
            $display("FAIL drop_three: got %0d, expected 3", frames_dropped);
        end
        bnum = 6'd9; doa = 8'd20; wbdone = 1'b1; fftdone = 1'b1;
        exp_q.push_back({8'd20, 6'd9});
        tick();
        wbdone = 1'b0;
        n_vec++;
        if ({result_valid, frames_dropped} !== {1'b1, 8'd4}) begin
            n_err++;
            $display("FAIL drop_with_wbdone: got rv=%b dropped=%0d, expected 1 4", result_valid, frames_dropped);
        end
        tick();
        fftdone = 1'b0;
        n_vec++;
        if ({detectstart, fft_hold, frames_dropped} !== {1'b1, 1'b1, 8'd4}) begin
            n_err++;
            $display("FAIL report_fftdone: got start=%b hold=%b dropped=%0d, expected 1 1 4",
                     detectstart, fft_hold, frames_dropped);
        end
        peakvalid = 1'b0; detectdone = 1'b1;
        tick();
        detectdone = 1'b0;
        for (int r = 0; r < 6; r++) begin
            fftdone = 1'b1;
            tick();
            for (int j = 0; j < 50; j++) tick();
            fftdone = 1'b0; peakvalid = 1'b0; detectdone = 1'b1;
            tick();
            detectdone = 1'b0;
            if (r == 0) begin
                n_vec++;
                if (frames_dropped !== 8'd54) begin
                    n_err++;
                    $display("FAIL drop_count: got %0d, expected 54", frames_dropped);
                end
            end
        end
        n_vec++;
        if (frames_dropped !== 8'd255) begin
            n_err++;
            $display("FAIL drop_saturate: got %0d, expected 255", frames_dropped);
        end
    endtask

    task automatic test_reset_mid_weight();
        start_frame(10'd77);
        wb_rdaddr2 = 10'd5;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_vec++;
        if ({rdaddr1, rdaddr2, rdaddr3, rdaddr4, wb_maxbin, doa_out, bnum_out, frames_dropped,
             detectstart, wbstart, fft_hold, result_valid, timeout_err} !== 77'd0) begin
            n_err++;
            $display("FAIL reset_mid: got hold=%b wb_maxbin=%0d dropped=%0d terr=%b, expected all 0",
                     fft_hold, wb_maxbin, frames_dropped, timeout_err);
        end
        bnum = 6'd1; doa = 8'd1; wbdone = 1'b1;
        tick();
        wbdone = 1'b0;
        tick();
        n_vec++;
        if ({result_valid, doa_out} !== {1'b0, 8'd0}) begin
            n_err++;
            $display("FAIL reset_stray_wbdone: got rv=%b doa=%0d, expected 0 0", result_valid, doa_out);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_reject();
        test_stray();
        test_watchdog();
        test_back_to_back();
        test_reset_mid_weight();
        tick();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_results: got %0d outstanding, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
